// File: rtl/key_space_dispatcher.sv
// key_space_dispatcher
// Issues candidate secret keys to the parallel RC4 decrypt cores from one
// shared counter, so no two cores are ever handed the same key. Requests are
// served in registered round-robin order, issuing stops when the downstream
// arbiter raises stop_search, and exhaustion is flagged once every key in
// 0..KEY_MAX has been handed out without a hit.
// Optional macro KEY_DISPATCH_STATS_EN adds the keys_issued grant counter.

module key_space_dispatcher #(
   parameter int                   NUM_CORES = 4,
   parameter int                   KEY_WIDTH = 24,
   parameter logic [KEY_WIDTH-1:0] KEY_MAX   = 24'h3FFFFF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   stop_search,
   input  logic [NUM_CORES-1:0]   core_req,
   output logic [NUM_CORES-1:0]   core_grant,
   output logic [KEY_WIDTH-1:0]   core_key,
   output logic                   busy,
`ifdef KEY_DISPATCH_STATS_EN
   output logic                   exhausted,
   output logic [KEY_WIDTH:0]     keys_issued
`else
   output logic                   exhausted
`endif
);

   localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

   typedef enum logic [1:0] {
      IDLE,
      DISPATCH,
      STOPPED,
      EXHAUSTED
   } state_t;

   state_t             state;
   logic [KEY_WIDTH:0] next_key;
   logic [PTR_W-1:0]   rr_ptr;

   logic               req_found;
   logic [PTR_W-1:0]   grant_idx;
   logic [PTR_W-1:0]   scan_idx;
   logic               key_space_done;

   // The extra top bit of next_key lets it step past KEY_MAX without wrapping.
   assign key_space_done = (next_key > {1'b0, KEY_MAX});

   // Pick the first requesting core at or after rr_ptr, wrapping modulo NUM_CORES.
   always_comb begin
      req_found = 1'b0;
      grant_idx = '0;
      scan_idx  = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         scan_idx = PTR_W'((int'(rr_ptr) + i) % NUM_CORES);
         if (!req_found && core_req[scan_idx]) begin
            req_found = 1'b1;
            grant_idx = scan_idx;
         end
      end
   end

   // Single FSM: state, key counter, round-robin pointer and all registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         next_key    <= '0;
         rr_ptr      <= '0;
         core_grant  <= '0;
         core_key    <= '0;
         busy        <= 1'b0;
         exhausted   <= 1'b0;
`ifdef KEY_DISPATCH_STATS_EN
         keys_issued <= '0;
`endif
      end else begin
         core_grant <= '0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  state       <= DISPATCH;
                  next_key    <= '0;
                  rr_ptr      <= '0;
                  busy        <= 1'b1;
                  exhausted   <= 1'b0;
`ifdef KEY_DISPATCH_STATS_EN
                  keys_issued <= '0;
`endif
               end
            end
            DISPATCH: begin
               if (stop_search) begin
                  state <= STOPPED;
                  busy  <= 1'b0;
               end else if (key_space_done) begin
                  state     <= EXHAUSTED;
                  busy      <= 1'b0;
                  exhausted <= 1'b1;
               end else if (req_found) begin
                  core_grant[grant_idx] <= 1'b1;
                  core_key              <= next_key[KEY_WIDTH-1:0];
                  next_key              <= next_key + 1'b1;
                  rr_ptr                <= (grant_idx == PTR_W'(NUM_CORES - 1)) ?
                                           '0 : grant_idx + 1'b1;
`ifdef KEY_DISPATCH_STATS_EN
                  if (keys_issued < ({1'b0, KEY_MAX} + 1'b1))
                     keys_issued <= keys_issued + 1'b1;
`endif
               end
            end
            STOPPED: begin
               if (start && !stop_search) begin
                  state       <= DISPATCH;
                  next_key    <= '0;
                  rr_ptr      <= '0;
                  busy        <= 1'b1;
                  exhausted   <= 1'b0;
`ifdef KEY_DISPATCH_STATS_EN
                  keys_issued <= '0;
`endif
               end
            end
            EXHAUSTED: begin
               if (stop_search) begin
                  state     <= STOPPED;
                  exhausted <= 1'b0;
               end else if (start) begin
                  state       <= DISPATCH;
                  next_key    <= '0;
                  rr_ptr      <= '0;
                  busy        <= 1'b1;
                  exhausted   <= 1'b0;
`ifdef KEY_DISPATCH_STATS_EN
                  keys_issued <= '0;
`endif
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_key_space_dispatcher.sv
// tb_key_space_dispatcher
// Directed bench for key_space_dispatcher using a small key space
// (KEY_MAX = 15) so exhaustion is reached quickly. Honours the optional
// KEY_DISPATCH_STATS_EN macro for the keys_issued counter.

module tb_key_space_dispatcher;

   localparam int                NUM_CORES = 4;
   localparam int                KEY_WIDTH = 24;
   localparam logic [KEY_WIDTH-1:0] KEY_MAX = 24'h00000F;

   logic                 clk;
   logic                 reset;
   logic                 start;
   logic                 stop_search;
   logic [NUM_CORES-1:0] core_req;
   logic [NUM_CORES-1:0] core_grant;
   logic [KEY_WIDTH-1:0] core_key;
   logic                 busy;
   logic                 exhausted;
`ifdef KEY_DISPATCH_STATS_EN
   logic [KEY_WIDTH:0]   keys_issued;
`endif

   int total_checks;
   int bad_checks;

   key_space_dispatcher #(
      .NUM_CORES (NUM_CORES),
      .KEY_WIDTH (KEY_WIDTH),
      .KEY_MAX   (KEY_MAX)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .stop_search (stop_search),
      .core_req    (core_req),
      .core_grant  (core_grant),
      .core_key    (core_key),
      .busy        (busy),
`ifdef KEY_DISPATCH_STATS_EN
      .exhausted   (exhausted),
      .keys_issued (keys_issued)
`else
      .exhausted   (exhausted)
`endif
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its expected value and tally it.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total_checks++;
      if (observed !== expected) begin
         bad_checks++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Advance to just after the next rising edge, where outputs are stable.
   task automatic applyStimulus;
      @(posedge clk);
      #1;
   endtask

   // Check grant vector and key together for one issuing cycle.
   task automatic checkGrant(input string tag, input logic [3:0] exp_grant,
                             input logic [23:0] exp_key);
      checkOutput({tag, "_grant"}, 32'(core_grant), 32'(exp_grant));
      checkOutput({tag, "_key"}, 32'(core_key), 32'(exp_key));
   endtask

   // Directed scenario sequence.
   initial begin
      logic [3:0] alt_grants [4];
      total_checks = 0;
      bad_checks   = 0;
      reset        = 1'b1;
      start        = 1'b0;
      stop_search  = 1'b0;
      core_req     = '0;
      alt_grants   = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};

      // Reset state.
      #12;
      checkOutput("rst_grant", 32'(core_grant), 32'd0);
      checkOutput("rst_key", 32'(core_key), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_exh", 32'(exhausted), 32'd0);
`ifdef KEY_DISPATCH_STATS_EN
      checkOutput("rst_issued", 32'(keys_issued), 32'd0);
`endif
      reset = 1'b0;

      // Requests in IDLE are ignored.
      core_req = 4'hF;
      applyStimulus();
      applyStimulus();
      checkOutput("idle_grant", 32'(core_grant), 32'd0);
      checkOutput("idle_busy", 32'(busy), 32'd0);

      // Start: busy next cycle, no grant yet.
      core_req = '0;
      start    = 1'b1;
      applyStimulus();
      start = 1'b0;
      checkOutput("start_busy", 32'(busy), 32'd1);
      checkOutput("start_grant", 32'(core_grant), 32'd0);

      // All four cores requesting: round-robin 0,1,2,3,0,1,2,3, keys 0..7.
      core_req = 4'hF;
      for (int i = 0; i < 8; i++) begin
         applyStimulus();
         checkGrant($sformatf("rr%0d", i), 4'(1 << (i % 4)), 24'(i));
      end

      // Only cores 1 and 3: alternate with consecutive keys 8..11.
      core_req = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         applyStimulus();
         checkGrant($sformatf("alt%0d", i), alt_grants[i], 24'(8 + i));
      end

      // Single core 0 takes keys 12..15, the last being KEY_MAX.
      core_req = 4'b0001;
      for (int i = 0; i < 4; i++) begin
         applyStimulus();
         checkGrant($sformatf("tail%0d", i), 4'b0001, 24'(12 + i));
      end

      // Key space used up: no grant, exhausted, not busy.
      applyStimulus();
      checkOutput("exh_grant", 32'(core_grant), 32'd0);
      checkOutput("exh_flag", 32'(exhausted), 32'd1);
      checkOutput("exh_busy", 32'(busy), 32'd0);
`ifdef KEY_DISPATCH_STATS_EN
      checkOutput("exh_issued", 32'(keys_issued), 32'd16);
`endif
      applyStimulus();
      checkOutput("exh_hold_grant", 32'(core_grant), 32'd0);
      checkOutput("exh_hold_flag", 32'(exhausted), 32'd1);

      // Restart from EXHAUSTED, then stop while next_key = 5.
      core_req = 4'hF;
      start    = 1'b1;
      applyStimulus();
      start = 1'b0;
      checkOutput("restart_busy", 32'(busy), 32'd1);
      checkOutput("restart_exh", 32'(exhausted), 32'd0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus();
         checkGrant($sformatf("pre_stop%0d", i), 4'(1 << (i % 4)), 24'(i));
      end
      stop_search = 1'b1;
      applyStimulus();
      checkOutput("stop_grant", 32'(core_grant), 32'd0);
      checkOutput("stop_busy", 32'(busy), 32'd0);
`ifdef KEY_DISPATCH_STATS_EN
      checkOutput("stop_issued", 32'(keys_issued), 32'd5);
`endif

      // start with stop_search high is ignored in STOPPED.
      start = 1'b1;
      applyStimulus();
      start       = 1'b0;
      stop_search = 1'b0;
      checkOutput("stop_start_busy", 32'(busy), 32'd0);
      applyStimulus();
      checkOutput("stop_hold_busy", 32'(busy), 32'd0);
      checkOutput("stop_hold_grant", 32'(core_grant), 32'd0);

      // stop_search and start pulsed together: still STOPPED.
      stop_search = 1'b1;
      start       = 1'b1;
      applyStimulus();
      stop_search = 1'b0;
      start       = 1'b0;
      checkOutput("both_busy", 32'(busy), 32'd0);
      applyStimulus();
      checkOutput("both_hold_busy", 32'(busy), 32'd0);
      checkOutput("both_hold_exh", 32'(exhausted), 32'd0);

      // Legal restart from STOPPED, core 1 only gets key 0.
      core_req = 4'b0010;
      start    = 1'b1;
      applyStimulus();
      start = 1'b0;
      checkOutput("restart2_busy", 32'(busy), 32'd1);
      applyStimulus();
      checkGrant("c1", 4'b0010, 24'd0);

      // Reset mid-grant clears outputs immediately.
      #2;
      reset = 1'b1;
      #1;
      checkOutput("midrst_grant", 32'(core_grant), 32'd0);
      checkOutput("midrst_key", 32'(core_key), 32'd0);
      checkOutput("midrst_busy", 32'(busy), 32'd0);
      #2;
      reset    = 1'b0;
      core_req = 4'hF;

      // Start after reset: first grant to core 0 with key 0.
      @(negedge clk);
      start = 1'b1;
      applyStimulus();
      start = 1'b0;
      checkOutput("post_rst_busy", 32'(busy), 32'd1);
      applyStimulus();
      checkGrant("post_rst", 4'b0001, 24'd0);
`ifdef KEY_DISPATCH_STATS_EN
      checkOutput("post_rst_issued", 32'(keys_issued), 32'd1);
`endif

      $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
      $finish;
   end

endmodule
